// File: rtl/alarm_arb_pkg.sv
// Shared definitions for the alarm arbiter: FSM state encoding, default
// timing constants and a counter-width helper.
package alarm_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_TICK_DIV  = 1200000;   // 100 ms at 12 MHz
    localparam int DEF_ON_TICKS  = 3;
    localparam int DEF_OFF_TICKS = 2;
    localparam int DEF_BURST_W   = 4;

    // Bits needed to hold any value 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV enabled cycles, with a
// synchronous clear so each new grant starts on a fresh tick boundary.
module alarm_tick_gen
    import alarm_arb_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cnt_width(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next count: clear wins, otherwise count while enabled and wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_arbiter.sv
// Alarm arbiter: shares one buzzer enable between N_REQ requesters and plays
// the owner's burst pattern (ON_TICKS on / OFF_TICKS off, repeated).
// Build option: define ALARM_ARB_FIXED_PRIORITY_EN for fixed priority
// (lowest index wins, no round-robin pointer); default is round-robin.
module alarm_arbiter
    import alarm_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int BURST_W   = DEF_BURST_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BURST_W-1:0] bursts,
    input  logic [N_REQ-1:0]         cancel,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     alarm_en,
    output logic                     busy
);

    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = cnt_width(PH_MAX);

    logic [1:0]         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               alarm_en_q, alarm_en_d;
    logic               busy_q, busy_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [PH_W-1:0]    phase_q, phase_d;

    logic               win_found;
    logic [N_REQ-1:0]   win_onehot;
    logic [BURST_W-1:0] win_bursts;
    logic               tick;
    logic               tick_clr;
    logic               own_cancel;

`ifndef ALARM_ARB_FIXED_PRIORITY_EN
    localparam int IDX_W = cnt_width(N_REQ - 1);

    logic [IDX_W-1:0] last_q, last_d, win_idx;

    // Round-robin pick: first set req bit searching upward from last+1 with
    // wrap. Outer loop runs from the farthest offset down so the nearest
    // candidate is the final assignment.
    always_comb begin
        win_found  = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        win_bursts = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (((int'(last_q) + k) % N_REQ) == i)) begin
                    win_found     = 1'b1;
                    win_onehot    = '0;
                    win_onehot[i] = 1'b1;
                    win_idx       = IDX_W'(i);
                    win_bursts    = bursts[i*BURST_W +: BURST_W];
                end
            end
        end
    end

    // Pointer moves to the winner only when a grant is actually issued.
    always_comb begin
        last_d = last_q;
        if ((state_q == ST_IDLE) && win_found) begin
            last_d = win_idx;
        end
    end

    // Round-robin pointer; reset value makes requester 0 win first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_q <= IDX_W'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority pick: lowest set index wins.
    always_comb begin
        win_found  = 1'b0;
        win_onehot = '0;
        win_bursts = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found     = 1'b1;
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_bursts    = bursts[i*BURST_W +: BURST_W];
            end
        end
    end
`endif

    assign own_cancel = |(cancel & grant_q);

    alarm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (tick_clr),
        .en    (busy_q),
        .tick  (tick)
    );

    // Pattern FSM: grant in IDLE, count ticks through ON/OFF phases, finish
    // after the last ON phase (no trailing OFF). Owner cancel beats expiry.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        alarm_en_d = alarm_en_q;
        busy_d     = busy_q;
        burst_d    = burst_q;
        phase_d    = phase_q;
        tick_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_ON;
                    grant_d    = win_onehot;
                    alarm_en_d = 1'b1;
                    busy_d     = 1'b1;
                    burst_d    = win_bursts;
                    phase_d    = '0;
                    tick_clr   = 1'b1;
                end
            end
            ST_ON: begin
                if (own_cancel) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    alarm_en_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (tick) begin
                    if (phase_q == PH_W'(ON_TICKS - 1)) begin
                        phase_d = '0;
                        if (burst_q == BURST_W'(1)) begin
                            state_d    = ST_IDLE;
                            grant_d    = '0;
                            done_d     = grant_q;
                            alarm_en_d = 1'b0;
                            busy_d     = 1'b0;
                            burst_d    = '0;
                        end else begin
                            if (burst_q != '0) begin
                                burst_d = burst_q - BURST_W'(1);
                            end
                            state_d    = ST_OFF;
                            alarm_en_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (own_cancel) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    alarm_en_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (tick) begin
                    if (phase_q == PH_W'(OFF_TICKS - 1)) begin
                        phase_d    = '0;
                        state_d    = ST_ON;
                        alarm_en_d = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                alarm_en_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            alarm_en_q <= 1'b0;
            busy_q     <= 1'b0;
            burst_q    <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            alarm_en_q <= alarm_en_d;
            busy_q     <= busy_d;
            burst_q    <= burst_d;
            phase_q    <= phase_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = busy_q;
    // Gated by RESET so the buzzer goes quiet in the reset cycle itself.
    assign alarm_en = alarm_en_q & ~RESET;

endmodule

// File: tb/tb_alarm_arbiter.sv
// Self-checking bench for alarm_arbiter with a small timing configuration.
// A pattern-level model (owner + elapsed cycles since grant) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_alarm_arbiter;

    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 1;
    localparam int BW   = 4;
    localparam int PER  = (ONT + OFFT) * TD;   // one ON+OFF period in cycles
    localparam int ONC  = ONT * TD;            // ON length in cycles

    logic            CLK;
    logic            RESET;
    logic [N-1:0]    req;
    logic [N*BW-1:0] bursts;
    logic [N-1:0]    cancel;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            alarm_en;
    logic            busy;

    int errors = 0;
    int checks = 0;

    alarm_arbiter #(
        .N_REQ     (N),
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .BURST_W   (BW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req      (req),
        .bursts   (bursts),
        .cancel   (cancel),
        .grant    (grant),
        .done     (done),
        .alarm_en (alarm_en),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_owner = -1;
    int           m_last  = N - 1;
    int           m_n     = 0;
    int           m_b     = 0;
    logic [N-1:0] m_done  = '0;
    bit           model_on = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_owner = -1;
            m_last  = N - 1;
            m_n     = 0;
            m_done  = '0;
        end else begin
            m_done = '0;
            if (m_owner >= 0) begin
                logic [1:0] o;
                o = m_owner[1:0];
                if (cancel[o]) begin
                    m_owner = -1;
                end else begin
                    m_n++;
                    // B bursts end when the B-th ON window has elapsed
                    if (m_b != 0 && m_n == m_b * PER - OFFT * TD) begin
                        m_done[o] = 1'b1;
                        m_owner   = -1;
                    end
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    logic [1:0] c2;
                    c  = (m_last + k) % N;
                    c2 = c[1:0];
                    if (req[c2]) begin
                        m_owner = c;
                        m_last  = c;
                        m_b     = int'(4'(bursts >> (BW * c)));
                        m_n     = 0;
                        break;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            logic [N-1:0] eg;
            logic         ea;
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            ea = (m_owner >= 0) && ((m_n % PER) < ONC) && !RESET;
            chk("m_grant", 32'(grant), 32'(eg));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_alarm_en", 32'(alarm_en), 32'(ea));
            chk("m_busy", 32'(busy), 32'(m_owner >= 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_burst(input int i, input logic [BW-1:0] v);
        bursts[i*BW +: BW] = v;
    endtask

    initial begin
        RESET  = 1'b1;
        req    = '0;
        bursts = '0;
        cancel = '0;
        wait_cyc(1);
        model_on = 1'b1;
        wait_cyc(2);
        @(negedge CLK);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_alarm", 32'(alarm_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        wait_cyc(1);
        RESET = 1'b0;
        wait_cyc(2);

        // Single request, two bursts
        set_burst(1, 4'd2);
        req = 4'b0010;
        @(negedge CLK);
        chk("t1_grant_t", 32'(grant), 32'h0);
        wait_cyc(1);
        req = '0;
        @(negedge CLK);
        chk("t1_grant_t1", 32'(grant), 32'h2);
        chk("t1_alarm_t1", 32'(alarm_en), 32'h1);
        wait_cyc(8);
        @(negedge CLK);
        chk("t1_alarm_t9", 32'(alarm_en), 32'h0);
        chk("t1_grant_t9", 32'(grant), 32'h2);
        wait_cyc(4);
        @(negedge CLK);
        chk("t1_alarm_t13", 32'(alarm_en), 32'h1);
        wait_cyc(8);
        @(negedge CLK);
        chk("t1_done_t21", 32'(done), 32'h2);
        chk("t1_grant_t21", 32'(grant), 32'h0);
        wait_cyc(1);
        @(negedge CLK);
        chk("t1_done_t22", 32'(done), 32'h0);

        // Round-robin from a fresh reset, all requesting one burst
        RESET = 1'b1;
        wait_cyc(1);
        RESET = 1'b0;
        for (int i = 0; i < N; i++) set_burst(i, 4'd1);
        req = 4'b1111;
        wait_cyc(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("rr_grant", 32'(grant), 32'(1 << (k % N)));
            if (k == 4) req = '0;
            wait_cyc(8);
            @(negedge CLK);
            chk("rr_idle", 32'(grant), 32'h0);
            wait_cyc(1);
        end

        // Continuous pattern on requester 2, then owner cancel
        set_burst(2, 4'd0);
        req = 4'b0100;
        wait_cyc(1);
        req = '0;
        wait_cyc(110);
        @(negedge CLK);
        chk("cont_grant", 32'(grant), 32'h4);
        chk("cont_alarm", 32'(alarm_en), 32'h1);
        cancel = 4'b0100;
        wait_cyc(1);
        cancel = '0;
        @(negedge CLK);
        chk("cont_cancel_grant", 32'(grant), 32'h0);
        chk("cont_cancel_alarm", 32'(alarm_en), 32'h0);
        chk("cont_cancel_done", 32'(done), 32'h0);

        // Foreign cancel is ignored
        set_burst(0, 4'd1);
        req = 4'b0001;
        wait_cyc(1);
        req = '0;
        wait_cyc(2);
        cancel = 4'b1000;
        wait_cyc(1);
        cancel = '0;
        @(negedge CLK);
        chk("fc_grant", 32'(grant), 32'h1);
        wait_cyc(5);
        @(negedge CLK);
        chk("fc_done", 32'(done), 32'h1);
        wait_cyc(1);

        // Cancel coincides with final ON expiry
        req = 4'b0001;
        wait_cyc(1);
        req = '0;
        wait_cyc(7);
        cancel = 4'b0001;
        wait_cyc(1);
        cancel = '0;
        @(negedge CLK);
        chk("sim_done", 32'(done), 32'h0);
        chk("sim_grant", 32'(grant), 32'h0);
        chk("sim_busy", 32'(busy), 32'h0);
        wait_cyc(1);

        // Reset in the middle of an OFF phase
        set_burst(0, 4'd2);
        req = 4'b0001;
        wait_cyc(1);
        req = '0;
        wait_cyc(9);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rm_alarm_in_rst", 32'(alarm_en), 32'h0);
        wait_cyc(1);
        RESET = 1'b0;
        set_burst(3, 4'd1);
        set_burst(0, 4'd1);
        req = 4'b1000;
        @(negedge CLK);
        chk("rm_grant", 32'(grant), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        wait_cyc(1);
        req = 4'b1001;
        @(negedge CLK);
        chk("rm_grant3", 32'(grant), 32'h8);
        wait_cyc(1);
        req = 4'b0001;
        wait_cyc(8);
        @(negedge CLK);
        chk("rm_grant0", 32'(grant), 32'h1);
        req = '0;
        wait_cyc(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
